// File: rtl/counter_load_arbiter_pkg.sv
// Shared types and constants for the counter load-port arbiter.
// The optional CNT_ARB_URGENT_EN build uses nothing extra from this package.
package counter_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        HOLDOFF = 2'd2
    } arb_state_e;

    localparam int   HOLDOFF_W      = 4;
    localparam logic MODE_STEP      = 1'b0;
    localparam logic MODE_OVERWRITE = 1'b1;

    // Index increment that wraps at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/counter_load_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping, returned as a one-hot grant plus its index.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 0; off < N; off++) begin
            cand = IW'((int'(ptr_i) + off) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/counter_load_arbiter.sv
// Round-robin arbiter for the counter's overwrite port: one-cycle load pulse
// followed by a step-only holdoff. CNT_ARB_URGENT_EN adds the `urgent` input.
module counter_load_arbiter
    import counter_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int HOLDOFF = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_data,
`ifdef CNT_ARB_URGENT_EN
    input  logic                 urgent,
`endif
    output logic [N-1:0]         req_ready,
    output logic                 cnt_mode,
    output logic [W-1:0]         cnt_wdata,
    output logic [$clog2(N)-1:0] load_owner,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    // Handshake: requester i transfers on a rising edge where req_valid[i] and
    // req_ready[i] are both high; ready is only ever offered in IDLE, and a
    // requester holds valid and data stable until it sees ready.

    localparam int IW = $clog2(N);
    localparam logic [HOLDOFF_W-1:0] HOLD_INIT =
        HOLDOFF_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    arb_state_e           state_q, state_d;
    logic [HOLDOFF_W-1:0] hold_q, hold_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic                 mode_q, mode_d;
    logic [W-1:0]         wdata_q, wdata_d;

    logic [N-1:0]  rr_gnt;
    logic [N-1:0]  sel_gnt;
    logic [IW-1:0] rr_idx;
    logic [IW-1:0] sel_idx;
    logic          rr_any;
    logic          urgent_pick;
    logic          urgent_cut;
    logic          handshake;

`ifdef CNT_ARB_URGENT_EN
    assign urgent_pick = urgent & req_valid[0];
    assign urgent_cut  = urgent;
`else
    assign urgent_pick = 1'b0;
    assign urgent_cut  = 1'b0;
`endif

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx),
        .any_o (rr_any)
    );

    assign sel_gnt   = urgent_pick ? {{(N-1){1'b0}}, 1'b1} : rr_gnt;
    assign sel_idx   = urgent_pick ? '0 : rr_idx;
    assign handshake = (state_q == IDLE) && rr_any;
    // Gated by rst_n so no requester sees a grant while reset is held.
    assign req_ready = (rst_n && (state_q == IDLE)) ? sel_gnt : '0;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        wdata_d = wdata_q;
        mode_d  = MODE_STEP;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d = LOAD;
                    mode_d  = MODE_OVERWRITE;
                    wdata_d = req_data[sel_idx*W +: W];
                    owner_d = sel_idx;
                    if (!urgent_pick) begin
                        ptr_d = IW'(wrap_inc(int'(sel_idx), N));
                    end
                end
            end
            LOAD: begin
                if (HOLDOFF > 0) begin
                    state_d = counter_arb_pkg::HOLDOFF;
                    hold_d  = HOLD_INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            counter_arb_pkg::HOLDOFF: begin
                if (urgent_cut || (hold_q == '0)) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            mode_q  <= MODE_STEP;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            mode_q  <= mode_d;
            wdata_q <= wdata_d;
        end
    end

    assign cnt_mode   = mode_q;
    assign cnt_wdata  = wdata_q;
    assign load_owner = owner_q;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_counter_load_arbiter.sv
// Bench for counter_load_arbiter: three instances (HOLDOFF 2, 0, 15) share one
// stimulus stream, each checked every cycle against a cycle-count model.
module tb_counter_load_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;
    localparam int NI = 3;
`ifdef CNT_ARB_URGENT_EN
    localparam bit URG_EN = 1'b1;
`else
    localparam bit URG_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic           urgent = 1'b0;
    int             checks = 0;
    int             passes = 0;
    int             cyc = 0;
    logic [W-1:0]   exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Lowest search offset from the pointer wins; urgent overrides for requester 0.
    function automatic int pick(input logic [N-1:0] v, input int p, input logic urg);
        if (urg && v[0]) return 0;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    wire urg_now = URG_EN && urgent;

    for (genvar g = 0; g < NI; g++) begin : u
        localparam int H = (g == 0) ? 2 : ((g == 1) ? 0 : 15);
        logic [N-1:0]  rdy;
        logic          mode;
        logic [W-1:0]  wd;
        logic [IW-1:0] own;
        logic          bsy;
        logic [1:0]    st;

        counter_load_arbiter #(.N(N), .W(W), .HOLDOFF(H)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid),
            .req_data   (req_data),
`ifdef CNT_ARB_URGENT_EN
            .urgent     (urgent),
`endif
            .req_ready  (rdy),
            .cnt_mode   (mode),
            .cnt_wdata  (wd),
            .load_owner (own),
            .busy       (bsy),
            .dbg_state  (st)
        );

        // Model: a load opens a busy window of 1+H cycles; the first is the load pulse.
        int           left;
        int           ptr;
        int           m_own;
        logic [W-1:0] m_wd;
        logic         m_mode;
        int           gnt_idx_q[$];
        int           gnt_cyc_q[$];
        int           mode_cyc_q[$];

        always @(posedge clk or negedge rst_n) begin
            int gi;
            if (!rst_n) begin
                left <= 0; ptr <= 0; m_own <= 0; m_wd <= '0; m_mode <= 1'b0;
            end else begin
                m_mode <= 1'b0;
                if (left == 0) begin
                    if (req_valid != '0) begin
                        gi = pick(req_valid, ptr, urg_now);
                        left   <= 1 + H;
                        m_mode <= 1'b1;
                        m_own  <= gi;
                        m_wd   <= req_data[gi*W +: W];
                        if (!(urg_now && req_valid[0])) ptr <= (gi + 1) % N;
                    end
                end else if (urg_now && left <= H) begin
                    left <= 0;
                end else begin
                    left <= left - 1;
                end
            end
        end

        always @(negedge clk) begin
            logic [N-1:0] er;
            logic [1:0]   es;
            er = '0;
            if (rst_n && left == 0 && req_valid != '0) er[pick(req_valid, ptr, urg_now)] = 1'b1;
            es = (left == 0) ? 2'd0 : (m_mode ? 2'd1 : 2'd2);
            chk($sformatf("h%0d_ready", H), rdy, er);
            chk($sformatf("h%0d_mode", H), mode, m_mode);
            chk($sformatf("h%0d_wdata", H), wd, m_wd);
            chk($sformatf("h%0d_owner", H), own, m_own);
            chk($sformatf("h%0d_busy", H), bsy, (left != 0));
            chk($sformatf("h%0d_state", H), st, es);
            if (rst_n && (rdy & req_valid) != '0) begin
                for (int k = 0; k < N; k++) if (rdy[k]) gnt_idx_q.push_back(k);
                gnt_cyc_q.push_back(cyc);
            end
            if (mode) mode_cyc_q.push_back(cyc);
        end
    end

    task automatic wait_rdy(input string name);
        int k;
        @(negedge clk);
        for (k = 0; k < 60 && u[0].rdy == '0; k++) @(negedge clk);
        if (k >= 60) begin
            checks++;
            $display("FAIL %s_timeout: got no ready in 60 cycles, required a grant", name);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_order(input string name, input int idxq[$], input int cycq[$],
                               input int n, input int spacing);
        chk({name, "_count"}, (idxq.size() >= n), 1);
        for (int k = 0; k < n && k < idxq.size(); k++) begin
            chk($sformatf("%s_idx%0d", name, k), idxq[k], exp_q[k]);
            if (k > 0) chk($sformatf("%s_gap%0d", name, k), cycq[k] - cycq[k-1], spacing);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Reset: outputs low even with every requester valid.
        req_valid = 4'b1111;
        req_data  = 32'h4030_2010;
        cycles(2);
        @(negedge clk);
        chk("rst_ready", u[0].rdy, 0);
        chk("rst_mode", u[0].mode, 0);
        chk("rst_wdata", u[0].wd, 0);
        chk("rst_owner", u[0].own, 0);
        chk("rst_busy", u[0].bsy, 0);
        req_valid = '0;
        cycles(1);
        rst_n = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (u[0].mode) n++;
        end
        chk("idle_20_no_load", n, 0);

        // Single request from requester 1.
        cycles(1);
        req_valid = 4'b0010;
        req_data  = 32'h0000_AA00;
        wait_rdy("single");
        chk("single_ready", u[0].rdy, 4'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("single_mode", u[0].mode, 1);
        chk("single_wdata", u[0].wd, 8'hAA);
        chk("single_owner", u[0].own, 1);
        n = 1;
        for (int k = 0; k < 40 && u[0].bsy; k++) begin
            @(negedge clk);
            if (u[0].bsy) n++;
        end
        chk("single_busy_len", n, 3);
        @(negedge clk);
        chk("single_wdata_held", u[0].wd, 8'hAA);

        // Reset while the load pulse is on the port.
        cycles(20);
        req_valid = 4'b0100;
        req_data  = 32'h0055_0000;
        wait_rdy("midload");
        @(posedge clk); #1;
        req_valid = '0;
        chk("midload_mode_high", u[0].mode, 1);
        rst_n = 1'b0;
        #1;
        chk("midload_mode_async", u[0].mode, 0);
        chk("midload_busy_async", u[0].bsy, 0);
        cycles(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midload_state_idle", u[0].st, 0);

        // Fairness: all four valid continuously; first grant proves pointer reset to 0.
        for (int g = 0; g < NI; g++) begin end
        u[0].gnt_idx_q.delete(); u[0].gnt_cyc_q.delete();
        u[1].gnt_idx_q.delete(); u[1].gnt_cyc_q.delete();
        u[2].gnt_idx_q.delete(); u[2].gnt_cyc_q.delete(); u[2].mode_cyc_q.delete();
        cycles(1);
        req_valid = 4'b1111;
        req_data  = 32'h4030_2010;
        cycles(44);
        req_valid = '0;
        exp_q = {8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
        check_order("fair_h2", u[0].gnt_idx_q, u[0].gnt_cyc_q, 5, 4);
        check_order("fair_h0", u[1].gnt_idx_q, u[1].gnt_cyc_q, 5, 2);
        check_order("fair_h15", u[2].gnt_idx_q, u[2].gnt_cyc_q, 2, 17);
        chk("h15_mode_count", (u[2].mode_cyc_q.size() >= 2 && u[2].gnt_cyc_q.size() >= 2), 1);
        if (u[2].mode_cyc_q.size() >= 2 && u[2].gnt_cyc_q.size() >= 2) begin
            chk("h15_mode_first", u[2].mode_cyc_q[0], u[2].gnt_cyc_q[0] + 1);
            chk("h15_mode_second", u[2].mode_cyc_q[1], u[2].gnt_cyc_q[1] + 1);
        end

`ifdef CNT_ARB_URGENT_EN
        // Urgent: move pointer to 2, then urgent picks 0 without advancing it.
        cycles(20);
        req_valid = 4'b0010;
        wait_rdy("urg_setup");
        @(posedge clk); #1;
        req_valid = '0;
        cycles(20);
        req_valid = 4'b0101;
        urgent    = 1'b1;
        wait_rdy("urg_pick");
        chk("urg_ready0", u[0].rdy, 4'b0001);
        @(posedge clk); #1;
        urgent    = 1'b0;
        req_valid = 4'b0111;
        wait_rdy("urg_next");
        chk("urg_next_ready2", u[0].rdy, 4'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        // Urgent during a long holdoff returns to IDLE on the next edge.
        cycles(20);
        req_valid = 4'b0001;
        wait_rdy("urg_cut");
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        urgent = 1'b1;
        @(posedge clk); #1;
        urgent = 1'b0;
        @(negedge clk);
        chk("urg_cut_h15_idle", u[2].bsy, 0);
`endif

        cycles(5);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
